// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs (package)
// Purpose  : Shared encodings and defaults for the five-stage MIPS pipeline.
//            Holds the bubble encoding, the reset PC and halt word defaults,
//            the fetch-state encoding and a small PC increment helper.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_defs;

  // Encoding of an empty ID slot; an all-zero word is sll $0,$0,0
  localparam logic [31:0] NOP_WORD             = 32'h0000_0000;

  // Defaults used by the fetch stage parameters
  localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD    = 32'hFFFF_FFFF;
  localparam int          DEFAULT_DRAIN_CYCLES = 4;

  // Fetch control states
  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_DRAIN  = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  // Sequential PC increment; wraps modulo 2^32 by construction
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage : cpu_defs
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register. Loads either the fetched word with its
//            PC+4 (valid) or a bubble, but only when the load enable is high;
//            with the enable low it holds, even across a requested bubble.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        bubble,
  input  logic [31:0] pc4_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc4,
  output logic [31:0] instr,
  output logic        valid
);

  logic [31:0] r_pc4;
  logic [31:0] r_instr;
  logic        r_valid;

  // Enable-gated load of either the fetched instruction or a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc4   <= 32'h0;
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (en) begin
      if (bubble) begin
        r_pc4   <= 32'h0;
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else begin
        r_pc4   <= pc4_in;
        r_instr <= instr_in;
        r_valid <= 1'b1;
      end
    end
  end

  assign pc4   = r_pc4;
  assign instr = r_instr;
  assign valid = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage. Owns the PC, the next-PC selection
//            (sequential / redirect / hold) and the halt-drain controller,
//            and feeds the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD,
  parameter int          DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic        Halted
);

  // State encodings, mirrored from the shared fetch-state enum
  localparam logic [1:0] ST_RUN    = FS_RUN;
  localparam logic [1:0] ST_DRAIN  = FS_DRAIN;
  localparam logic [1:0] ST_HALTED = FS_HALTED;

  // Drain length reload value (legal range 1..15 fits the 4-bit counter)
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  logic [31:0] r_pc;
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;

  logic [31:0] w_pc_next;
  logic [1:0]  w_state_next;
  logic [3:0]  w_cnt_next;
  logic        w_bubble;
  logic [31:0] w_pc4;
  logic        w_is_halt;

  assign w_pc4     = pc_plus4(r_pc);
  assign w_is_halt = (ImemData == HALT_WORD);

  // Next-PC selection, halt detection and drain countdown
  always_comb begin
    w_pc_next    = r_pc;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bubble     = 1'b1;

    case (r_state)
      ST_RUN: begin
        w_bubble = 1'b0;
        // With PCWrite low the ID instruction is stalled and unresolved,
        // so neither a redirect nor a halt word may be acted on yet.
        if (PCWrite) begin
          if (Redirect) begin
            // Redirect wins over a halt word sitting in the branch shadow
            w_pc_next = RedirectTarget;
            w_bubble  = 1'b1;
          end else if (w_is_halt) begin
            w_bubble     = 1'b1;
            w_cnt_next   = DRAIN_INIT;
            w_state_next = ST_DRAIN;
          end else begin
            w_pc_next = w_pc4;
          end
        end
      end

      ST_DRAIN: begin
        // PC frozen; the counter runs down regardless of the hazard enables
        if (r_cnt <= 4'd1) begin
          w_cnt_next   = 4'd0;
          w_state_next = ST_HALTED;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end

      ST_HALTED: begin
        w_cnt_next = 4'd0;
      end

      default: begin
        w_cnt_next   = 4'd0;
        w_state_next = ST_RUN;
      end
    endcase
  end

  // PC, fetch state and drain counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .en       (IF_ID_Write),
    .bubble   (w_bubble),
    .pc4_in   (w_pc4),
    .instr_in (ImemData),
    .pc4      (IF_ID_PC4),
    .instr    (IF_ID_Instr),
    .valid    (IF_ID_Valid)
  );

  assign ImemAddr = r_pc;
  assign Halted   = (r_state == ST_HALTED);

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed bench for if_stage. The driver pushes the expected
//            post-edge outputs for every cycle it drives; a separate monitor
//            pops and compares one entry just after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCWrite = 1'b0;
  logic        IF_ID_Write = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectTarget = 32'h0;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
  logic        Halted;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    string       name;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem [0:63];

  if_stage #(
    .RESET_PC     (32'h0000_0000),
    .HALT_WORD    (32'hFFFF_FFFF),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .ImemAddr       (ImemAddr),
    .ImemData       (ImemData),
    .IF_ID_PC4      (IF_ID_PC4),
    .IF_ID_Instr    (IF_ID_Instr),
    .IF_ID_Valid    (IF_ID_Valid),
    .Halted         (Halted)
  );

  always #5 clk = ~clk;

  // Asynchronous-read instruction memory, 64 words, address bits [7:2]
  assign ImemData = mem[ImemAddr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.name, ".addr"},   ImemAddr,           e.addr);
    chk({e.name, ".pc4"},    IF_ID_PC4,          e.pc4);
    chk({e.name, ".instr"},  IF_ID_Instr,        e.instr);
    chk({e.name, ".valid"},  {31'h0, IF_ID_Valid}, {31'h0, e.valid});
    chk({e.name, ".halted"}, {31'h0, Halted},      {31'h0, e.halted});
  endtask

  // Monitor: one scoreboard entry is due just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) chk_all(sb.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic pw, input logic iw, input logic rd,
                      input logic [31:0] tgt, input logic [31:0] e_addr,
                      input logic [31:0] e_pc4, input logic [31:0] e_instr,
                      input logic e_v, input logic e_h, input string name);
    exp_t e;
    @(negedge clk);
    PCWrite        = pw;
    IF_ID_Write    = iw;
    Redirect       = rd;
    RedirectTarget = tgt;
    e.addr = e_addr; e.pc4 = e_pc4; e.instr = e_instr;
    e.valid = e_v; e.halted = e_h; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Assert reset mid-cycle, check reset values before any edge, then release
  task automatic do_reset(input string name);
    exp_t e;
    wait_drain();
    @(negedge clk);
    PCWrite = 1'b0; IF_ID_Write = 1'b0; Redirect = 1'b0; RedirectTarget = 32'h0;
    #1 reset = 1'b1;
    #1;
    e.addr = 32'h0; e.pc4 = 32'h0; e.instr = 32'h0; e.valid = 1'b0;
    e.halted = 1'b0; e.name = name;
    chk_all(e);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h2001_0005;
    mem[1]  = 32'h2002_0007;
    mem[2]  = 32'h2003_0009;
    mem[3]  = 32'h2004_000B;
    mem[4]  = 32'h1000_000B;
    mem[5]  = HALT;
    mem[16] = 32'h2005_0001;
    mem[17] = 32'h0800_0005;
    mem[18] = 32'h2006_0002;
    mem[63] = 32'h2007_000F;

    do_reset("reset0");

    //    pw iw rd target        addr          pc4           instr         v  h
    step(1, 1, 0, 32'h0,        32'h4,        32'h4,        32'h2001_0005, 1, 0, "fetch0");
    step(1, 1, 0, 32'h0,        32'h8,        32'h8,        32'h2002_0007, 1, 0, "fetch4");
    step(0, 0, 0, 32'h0,        32'h8,        32'h8,        32'h2002_0007, 1, 0, "stall1");
    step(0, 0, 1, 32'h80,       32'h8,        32'h8,        32'h2002_0007, 1, 0, "stall_redir");
    step(1, 1, 0, 32'h0,        32'hC,        32'hC,        32'h2003_0009, 1, 0, "release");
    step(1, 1, 0, 32'h0,        32'h10,       32'h10,       32'h2004_000B, 1, 0, "fetchC");
    step(1, 1, 1, 32'h40,       32'h40,       32'h0,        32'h0,         0, 0, "branch40");
    step(1, 1, 0, 32'h0,        32'h44,       32'h44,       32'h2005_0001, 1, 0, "fetch40");
    step(1, 1, 1, 32'h14,       32'h14,       32'h0,        32'h0,         0, 0, "jump14");
    step(1, 1, 0, 32'h0,        32'h14,       32'h0,        32'h0,         0, 0, "halt_det");
    step(1, 1, 0, 32'h0,        32'h14,       32'h0,        32'h0,         0, 0, "drain1");
    step(1, 1, 1, 32'h40,       32'h14,       32'h0,        32'h0,         0, 0, "drain2");
    step(1, 1, 0, 32'h0,        32'h14,       32'h0,        32'h0,         0, 0, "drain3");
    step(1, 1, 0, 32'h0,        32'h14,       32'h0,        32'h0,         0, 1, "halted");
    step(1, 1, 1, 32'h40,       32'h14,       32'h0,        32'h0,         0, 1, "halt_redir");
    step(0, 0, 0, 32'h0,        32'h14,       32'h0,        32'h0,         0, 1, "halt_hold");

    do_reset("reset_halted");

    // Halt word in a branch shadow: redirect wins, no drain follows
    step(1, 1, 1, 32'h14,       32'h14,       32'h0,        32'h0,         0, 0, "to14");
    step(1, 1, 1, 32'h48,       32'h48,       32'h0,        32'h0,         0, 0, "halt_shadow");
    step(1, 1, 0, 32'h0,        32'h4C,       32'h4C,       32'h2006_0002, 1, 0, "after_shadow");

    // Wrap of PC+4 and an unaligned redirect target
    step(1, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'h0,         0, 0, "to_top");
    step(1, 1, 0, 32'h0,        32'h0,        32'h0,        32'h2007_000F, 1, 0, "wrap");
    step(1, 1, 1, 32'h42,       32'h42,       32'h0,        32'h0,         0, 0, "unaligned");
    step(1, 1, 0, 32'h0,        32'h46,       32'h46,       32'h2005_0001, 1, 0, "fetch42");

    // Enter drain, then reset part-way through it
    step(1, 1, 1, 32'h14,       32'h14,       32'h0,        32'h0,         0, 0, "to14b");
    step(1, 1, 0, 32'h0,        32'h14,       32'h0,        32'h0,         0, 0, "halt_det2");
    step(1, 1, 0, 32'h0,        32'h14,       32'h0,        32'h0,         0, 0, "drain_b1");

    do_reset("reset_drain");

    // Clean restart after mid-drain reset; then reset again mid-stall
    step(1, 1, 0, 32'h0,        32'h4,        32'h4,        32'h2001_0005, 1, 0, "restart0");
    step(1, 1, 0, 32'h0,        32'h8,        32'h8,        32'h2002_0007, 1, 0, "restart4");
    step(0, 0, 0, 32'h0,        32'h8,        32'h8,        32'h2002_0007, 1, 0, "stall_b");

    do_reset("reset_stall");

    step(1, 1, 0, 32'h0,        32'h4,        32'h4,        32'h2001_0005, 1, 0, "restart_b");
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_if_stage
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS CPU. The block holds the PC and presents it to instruction memory. It latches the fetched word and PC+4 into IF/ID. It obeys the hazard unit's PCWrite/IF_ID_Write hold, squashes on taken branch/jump/jr, and stops fetch cleanly on a halt word with a drain period.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that ends fetch
- DRAIN_CYCLES, 4, cycles after halt fetch before Halted asserts (1..15)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- PCWrite  in  1  from hazard unit; 0 holds PC
- IF_ID_Write  in  1  from hazard unit; 0 holds IF/ID register
- Redirect  in  1  taken branch/j/jal/jr resolved in ID this cycle
- RedirectTarget  in  32  next PC when Redirect=1
- ImemAddr  out  32  current PC, combinational from PC register
- ImemData  in  32  instruction at ImemAddr, same cycle (async-read memory)
- IF_ID_PC4  out  32  registered PC+4 of instruction in ID
- IF_ID_Instr  out  32  registered instruction in ID (0 = bubble)
- IF_ID_Valid  out  1  1 when IF_ID_Instr is a real instruction
- Halted  out  1  fetch stopped and drain complete

## Operation
- States: RUN, DRAIN, HALTED. A 4-bit drain counter is used.
- RUN, advance = PCWrite:
  - Redirect=1: PC←RedirectTarget; IF/ID←bubble (Instr=0, Valid=0, PC4=0). This squashes the wrong-path fetch.
  - Redirect=0, ImemData==HALT_WORD: PC holds; IF/ID←bubble; counter←DRAIN_CYCLES; go DRAIN.
  - Otherwise: PC←PC+4; IF/ID←{PC+4, ImemData, Valid=1}.
- RUN, PCWrite=0: PC holds. Redirect and halt detection are ignored, because the ID instruction is stalled and unresolved.
- IF/ID load is additionally gated by IF_ID_Write. When IF_ID_Write=0, IF/ID holds, including over a squash or bubble. Hazard unit asserts both enables together.
- DRAIN: PC frozen. IF/ID←bubble whenever IF_ID_Write=1. Counter decrements every cycle, and at 1 goes HALTED. Redirect is ignored.
- HALTED: identical to DRAIN with the counter idle, and Halted=1. Only reset exits.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). RedirectTarget is used unaligned as given; the low 2 bits are not masked.
- Halt word in a branch shadow: Redirect in the same cycle wins and the halt is discarded.

## Timing
- Reset values: PC=RESET_PC, so ImemAddr=RESET_PC. IF_ID_PC4=0, IF_ID_Instr=0, IF_ID_Valid=0, Halted=0, state RUN, counter 0.
- The first edge after reset deasserts fetches RESET_PC. Its instruction is visible on IF_ID_* one cycle later.
- Fetch-to-ID latency is 1 cycle. Redirect costs exactly 1 bubble.
- Halted rises DRAIN_CYCLES edges after the edge that detected HALT_WORD.
- Reset asserted mid-DRAIN or mid-stall returns to reset values asynchronously, with no partial update.

## Structure
- Shared package `cpu_defs`: NOP/bubble encoding 32'h0, default RESET_PC, HALT_WORD, and the fetch state enum (RUN/DRAIN/HALTED).
- One natural sub-module: `if_id_reg`, the enable-plus-bubble pipeline register holding PC4/Instr/Valid. PC, next-PC mux and FSM stay in `if_stage`.

## Test plan
- Reset, then imem returns 0x20010005,0x20020007,… with enables 1: ImemAddr 0,4,8. IF_ID_Instr=0x20010005, PC4=4, Valid=1 one cycle after the first edge.
- PCWrite=IF_ID_Write=0 for 2 cycles at PC=8: ImemAddr stays 8 and IF/ID holds its word. Release resumes at 0xC.
- Redirect=1, target 0x40, at PC=0x10: next ImemAddr=0x40 and IF/ID is a bubble (Valid=0). The following cycle loads the word at 0x40 with PC4=0x44.
- Redirect asserted with PCWrite=0: PC unchanged and no bubble inserted.
- HALT_WORD at 0x14, DRAIN_CYCLES=4: PC frozen at 0x14 and IF/ID bubbles. Halted=1 exactly 4 edges later and stays 1. Redirect in HALTED is ignored.
- HALT_WORD fetched with Redirect=1 in the same cycle → PC←target and no DRAIN. Async reset during DRAIN → all outputs at reset values before the next edge.
